// File: rtl/in_stream_desync.sv
// Stochastic bitstream decorrelator: pushes two streams toward minimal overlap
// (SCC = -1) by saving colliding 1s and replaying them into idle cycles.
module in_stream_desync #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bypass,
  input  logic          in_a,
  input  logic          in_b,
  output logic          out_a,
  output logic          out_b,
  output logic [CW-1:0] pend_a,
  output logic [CW-1:0] pend_b
);

  localparam logic [CW-1:0] CMAX  = CW'(DEPTH);
  localparam logic          PRI_A = 1'b0;
  localparam logic          PRI_B = 1'b1;

  logic [CW-1:0] cnt_a_q, cnt_a_d;
  logic [CW-1:0] cnt_b_q, cnt_b_d;
  logic          pri_q, pri_d;
  logic          out_a_q, out_a_d;
  logic          out_b_q, out_b_d;
  logic          have_a, have_b;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    pri_d   = pri_q;
    out_a_d = in_a;
    out_b_d = in_b;
    have_a  = (cnt_a_q != '0);
    have_b  = (cnt_b_q != '0);
    if (!bypass) begin
      case ({in_a, in_b})
        2'b11: begin
          // Keep one side's 1, bank the other; a full bank lets the overlap through.
          if (pri_q == PRI_A && cnt_b_q != CMAX) begin
            out_b_d = 1'b0;
            cnt_b_d = cnt_b_q + 1'b1;
            pri_d   = PRI_B;
          end else if (pri_q == PRI_B && cnt_a_q != CMAX) begin
            out_a_d = 1'b0;
            cnt_a_d = cnt_a_q + 1'b1;
            pri_d   = PRI_A;
          end
        end
        2'b00: begin
          if (have_a && have_b) begin
            if (pri_q == PRI_A) begin
              out_a_d = 1'b1;
              cnt_a_d = cnt_a_q - 1'b1;
            end else begin
              out_b_d = 1'b1;
              cnt_b_d = cnt_b_q - 1'b1;
            end
            pri_d = ~pri_q;
          end else if (have_a) begin
            out_a_d = 1'b1;
            cnt_a_d = cnt_a_q - 1'b1;
          end else if (have_b) begin
            out_b_d = 1'b1;
            cnt_b_d = cnt_b_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      pri_q   <= PRI_A;
      out_a_q <= 1'b0;
      out_b_q <= 1'b0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      pri_q   <= pri_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  assign out_a  = out_a_q;
  assign out_b  = out_b_q;
  assign pend_a = cnt_a_q;
  assign pend_b = cnt_b_q;

endmodule

// File: tb/tb_in_stream_desync.sv
// Bench for in_stream_desync: directed scenarios on DEPTH=2 plus a randomized
// scoreboard run against DEPTH=1,2,4 instances sharing the same inputs.
module tb_in_stream_desync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, bypass, in_a, in_b;
  logic [2:0] oa_w, ob_w;
  logic [0:0] pa0, pb0;
  logic [1:0] pa1, pb1;
  logic [2:0] pa2, pb2;

  in_stream_desync #(.DEPTH(1)) u_d1 (.clk(clk), .rst(rst), .bypass(bypass), .in_a(in_a), .in_b(in_b),
    .out_a(oa_w[0]), .out_b(ob_w[0]), .pend_a(pa0), .pend_b(pb0));
  in_stream_desync #(.DEPTH(2)) u_d2 (.clk(clk), .rst(rst), .bypass(bypass), .in_a(in_a), .in_b(in_b),
    .out_a(oa_w[1]), .out_b(ob_w[1]), .pend_a(pa1), .pend_b(pb1));
  in_stream_desync #(.DEPTH(4)) u_d4 (.clk(clk), .rst(rst), .bypass(bypass), .in_a(in_a), .in_b(in_b),
    .out_a(oa_w[2]), .out_b(ob_w[2]), .pend_a(pa2), .pend_b(pb2));

  int n_cmp = 0;
  int n_bad = 0;

  int depths[3] = '{1, 2, 4};
  // reference model state: banked 1s per stream, whose turn it is (0=A,1=B)
  int m_ca[3], m_cb[3], m_pri[3], m_oa[3], m_ob[3];
  int in_tot_a[3], in_tot_b[3], out_tot_a[3], out_tot_b[3];
  int sat_cnt[3], ovl_cnt[3];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int get_pa(input int k);
    case (k)
      0: return int'(pa0);
      1: return int'(pa1);
      default: return int'(pa2);
    endcase
  endfunction

  function automatic int get_pb(input int k);
    case (k)
      0: return int'(pb0);
      1: return int'(pb1);
      default: return int'(pb2);
    endcase
  endfunction

  task automatic model_step(input int k, input bit r, input bit byp, input bit a, input bit b);
    int d;
    d = depths[k];
    if (r) begin
      m_ca[k] = 0; m_cb[k] = 0; m_pri[k] = 0; m_oa[k] = 0; m_ob[k] = 0;
      in_tot_a[k] = 0; in_tot_b[k] = 0; out_tot_a[k] = 0; out_tot_b[k] = 0;
    end else if (byp) begin
      m_oa[k] = a; m_ob[k] = b;
    end else if (a && b) begin
      if (m_pri[k] == 0 && m_cb[k] < d) begin
        m_oa[k] = 1; m_ob[k] = 0; m_cb[k]++; m_pri[k] = 1;
      end else if (m_pri[k] == 1 && m_ca[k] < d) begin
        m_oa[k] = 0; m_ob[k] = 1; m_ca[k]++; m_pri[k] = 0;
      end else begin
        m_oa[k] = 1; m_ob[k] = 1; sat_cnt[k]++;
      end
    end else if (!a && !b) begin
      m_oa[k] = 0; m_ob[k] = 0;
      if (m_ca[k] > 0 && m_cb[k] > 0) begin
        if (m_pri[k] == 0) begin m_oa[k] = 1; m_ca[k]--; end
        else begin m_ob[k] = 1; m_cb[k]--; end
        m_pri[k] = 1 - m_pri[k];
      end else if (m_ca[k] > 0) begin
        m_oa[k] = 1; m_ca[k]--;
      end else if (m_cb[k] > 0) begin
        m_ob[k] = 1; m_cb[k]--;
      end
    end else begin
      m_oa[k] = a; m_ob[k] = b;
    end
  endtask

  // one clock: drive, let the edge happen, then score every instance
  task automatic cycle(input bit r, input bit byp, input bit a, input bit b);
    rst = r; bypass = byp; in_a = a; in_b = b;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      model_step(k, r, byp, a, b);
      chk($sformatf("d%0d_out_a", depths[k]), int'(oa_w[k]), m_oa[k]);
      chk($sformatf("d%0d_out_b", depths[k]), int'(ob_w[k]), m_ob[k]);
      chk($sformatf("d%0d_pend_a", depths[k]), get_pa(k), m_ca[k]);
      chk($sformatf("d%0d_pend_b", depths[k]), get_pb(k), m_cb[k]);
      if (!r) begin
        in_tot_a[k] += int'(a);
        in_tot_b[k] += int'(b);
        out_tot_a[k] += int'(oa_w[k]);
        out_tot_b[k] += int'(ob_w[k]);
        chk($sformatf("d%0d_cons_a", depths[k]), out_tot_a[k] + get_pa(k), in_tot_a[k]);
        chk($sformatf("d%0d_cons_b", depths[k]), out_tot_b[k] + get_pb(k), in_tot_b[k]);
        if (!byp && oa_w[k] && ob_w[k]) ovl_cnt[k]++;
      end
    end
  endtask

  // directed checks against literal expectations on the DEPTH=2 instance
  task automatic exp2(input string tag, input int oa, input int ob, input int pa, input int pb);
    chk({tag, "_oa"}, int'(oa_w[1]), oa);
    chk({tag, "_ob"}, int'(ob_w[1]), ob);
    chk({tag, "_pa"}, int'(pa1), pa);
    chk({tag, "_pb"}, int'(pb1), pb);
  endtask

  int sat_oa[5] = '{1, 0, 1, 0, 1};
  int sat_ob[5] = '{0, 1, 0, 1, 1};
  int drn_oa[4] = '{1, 0, 1, 0};
  int drn_ob[4] = '{0, 1, 0, 1};

  initial begin
    int tot_a, tot_b, p_a, p_b;
    bit ra, rb, rbyp;
    rst = 1'b1; bypass = 1'b0; in_a = 1'b1; in_b = 1'b1;

    // reset holds everything at zero regardless of inputs
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, 1);
      exp2("rst", 0, 0, 0, 0);
    end

    // single overlap, then pri=B is visible through the next overlap
    cycle(0, 0, 1, 1); exp2("ovl1", 1, 0, 0, 1);
    cycle(0, 0, 0, 0); exp2("ovl2", 0, 1, 0, 0);
    cycle(0, 0, 1, 1); exp2("ovl3", 0, 1, 1, 0);
    cycle(0, 0, 0, 0); exp2("ovl4", 1, 0, 0, 0);

    // saturation and drain
    cycle(1, 0, 0, 0);
    tot_a = 0; tot_b = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 1);
      chk($sformatf("sat%0d_oa", i), int'(oa_w[1]), sat_oa[i]);
      chk($sformatf("sat%0d_ob", i), int'(ob_w[1]), sat_ob[i]);
      tot_a += int'(oa_w[1]); tot_b += int'(ob_w[1]);
    end
    chk("sat_pa", int'(pa1), 2);
    chk("sat_pb", int'(pb1), 2);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0);
      chk($sformatf("drn%0d_oa", i), int'(oa_w[1]), drn_oa[i]);
      chk($sformatf("drn%0d_ob", i), int'(ob_w[1]), drn_ob[i]);
      tot_a += int'(oa_w[1]); tot_b += int'(ob_w[1]);
    end
    exp2("drn_end", 0, 1, 0, 0);
    chk("sat_tot_a", tot_a, 5);
    chk("sat_tot_b", tot_b, 5);

    // bypass freezes state, draining resumes afterwards
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 1); exp2("byp0", 1, 0, 0, 1);
    cycle(0, 1, 1, 1); exp2("byp1", 1, 1, 0, 1);
    cycle(0, 1, 1, 1); exp2("byp2", 1, 1, 0, 1);
    cycle(0, 0, 0, 0); exp2("byp3", 0, 1, 0, 0);

    // reset mid-operation discards banked bits
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1); exp2("mid_pre", 0, 1, 2, 1);
    cycle(1, 0, 0, 0); exp2("mid_rst", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      exp2("mid_post", 0, 0, 0, 0);
    end

    // randomized scoreboard
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin sat_cnt[k] = 0; ovl_cnt[k] = 0; end
    p_a = 50; p_b = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 500 == 0) begin
        p_a = $urandom_range(100);
        p_b = $urandom_range(100);
      end
      ra   = ($urandom_range(99) < p_a);
      rb   = ($urandom_range(99) < p_b);
      rbyp = ($urandom_range(99) < 5);
      cycle(0, rbyp, ra, rb);
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("d%0d_ovl_vs_sat", depths[k]), ovl_cnt[k], sat_cnt[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/in_stream_desync.md
IN_STREAM_DESYNC -- requirements
Module: in_stream_desync

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the maximum saved bits per stream; legal range 1..15.
REQ-002 The block SHALL have parameter CW, default $clog2(DEPTH+1), giving the width of each pending counter.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port bypass  input  1  when 1, inputs SHALL pass to outputs (registered) without decorrelation.
REQ-006 Port in_a  input  1  stochastic bitstream A.
REQ-007 Port in_b  input  1  stochastic bitstream B.
REQ-008 Port out_a  output  1  registered, decorrelated bitstream A.
REQ-009 Port out_b  output  1  registered, decorrelated bitstream B.
REQ-010 Port pend_a  output  CW  saved-bit count for A (cnt_a).
REQ-011 Port pend_b  output  CW  saved-bit count for B (cnt_b).

Function
REQ-012 The block SHALL be the inverse of the skewed synchronizer: it drives two streams toward SCC = -1 (minimal overlap) while preserving each stream's count of 1s.
REQ-013 State SHALL be cnt_a and cnt_b (each 0..DEPTH) plus a priority bit pri (A or B); out_a and out_b SHALL be flops with 1-cycle latency from the inputs.
REQ-014 Pending outputs SHALL show current state: pend_a = cnt_a, pend_b = cnt_b.
REQ-015 For input (in_a, in_b) = (1,0) the block SHALL emit (1,0); for (0,1) it SHALL emit (0,1); counters and pri SHALL be unchanged.
REQ-016 For (1,1) with pri=A and cnt_b<DEPTH, the block SHALL emit (1,0), increment cnt_b, and set pri=B.
REQ-017 For (1,1) with pri=B and cnt_a<DEPTH, the block SHALL emit (0,1), increment cnt_a, and set pri=A.
REQ-018 For (1,1) when the counter selected by pri is at DEPTH (saturation), the block SHALL emit (1,1); counters and pri SHALL be unchanged.
REQ-019 For (0,0) with both counters >0, the block SHALL emit one saved bit on the side selected by pri, decrement that counter, and flip pri.
REQ-020 For (0,0) with only cnt_a>0, the block SHALL emit (1,0) and decrement cnt_a; pri SHALL be unchanged.
REQ-021 For (0,0) with only cnt_b>0, the block SHALL emit (0,1) and decrement cnt_b; pri SHALL be unchanged.
REQ-022 For (0,0) with both counters 0, the block SHALL emit (0,0).
REQ-023 Counters SHALL never exceed DEPTH or wrap below 0.
REQ-024 Conservation invariant for each stream: ones_in = ones_out + cnt (one-cycle output latency accounted for).
REQ-025 When bypass=1, out_a and out_b SHALL take in_a and in_b the next cycle, and counters and pri SHALL hold.
REQ-026 Saved bits SHALL resume draining after bypass returns to 0.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set out_a=0, out_b=0, cnt_a=0, cnt_b=0, pri=A, regardless of in_a, in_b, and bypass.
REQ-028 A reset during operation SHALL discard saved bits; the conservation count restarts from the first cycle after reset.
REQ-029 The first cycle after reset SHALL behave per REQ-015..REQ-022 with pri=A.

Verification
REQ-030 Reset scenario: rst=1 for 3 cycles with in=(1,1) -> out=(0,0), pend=(0,0) throughout.
REQ-031 Single overlap: (1,1) then (0,0), DEPTH=2 -> out (1,0) then (0,1); pend_b goes 1 then 0; pri ends at B.
REQ-032 Saturation, DEPTH=2: (1,1) applied 5 cycles, then (0,0) applied 4 cycles.
 - Out during (1,1): (1,0), (0,1), (1,0), (0,1), (1,1).
 - Pend after the 5th cycle: (2,2).
 - Out during (0,0) drain: (1,0), (0,1), (1,0), (0,1); pend ends (0,0).
 - Totals: 5 ones in and 5 ones out per stream.
REQ-033 Bypass: cnt_b=1, then bypass=1 with in=(1,1) for 2 cycles -> out=(1,1) twice, pend_b stays 1. Then bypass=0 with (0,0) -> out=(0,1), pend_b=0.
REQ-034 Reset mid-operation: pend=(2,1), rst=1 for 1 cycle -> out=(0,0) and pend=(0,0) the next cycle; no stale bits emitted afterward.
REQ-035 Random stream scoreboard, 10k cycles, DEPTH in {1,2,4}, with random in_a, in_b and values p_a, p_b.
 - REQ-024 SHALL hold every cycle.
 - Overlap cycles on the outputs SHALL equal the saturation events of REQ-018 (bypass=0).
